// File: rtl/toe_pkg.sv
// Shared TOE definitions: protocol constants, parser word map, parser states and header record.
package toe_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 4;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_TCP  = 8'd6;
  localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [3:0]  IP_VERSION    = 4'd4;
  localparam logic [3:0]  IP_IHL        = 4'd5;
  localparam logic [3:0]  TCP_DOFF_MIN  = 4'd5;

  // Word index within a frame; the counter parks at W_SAT past the header.
  localparam logic [IDX_W-1:0] W_ETH0  = 4'd0;
  localparam logic [IDX_W-1:0] W_ETH1  = 4'd1;
  localparam logic [IDX_W-1:0] W_ETH2  = 4'd2;
  localparam logic [IDX_W-1:0] W_ETH3  = 4'd3;
  localparam logic [IDX_W-1:0] W_IP4   = 4'd4;
  localparam logic [IDX_W-1:0] W_IP5   = 4'd5;
  localparam logic [IDX_W-1:0] W_IP6   = 4'd6;
  localparam logic [IDX_W-1:0] W_IP7   = 4'd7;
  localparam logic [IDX_W-1:0] W_IP8   = 4'd8;
  localparam logic [IDX_W-1:0] W_TCP9  = 4'd9;
  localparam logic [IDX_W-1:0] W_TCP10 = 4'd10;
  localparam logic [IDX_W-1:0] W_TCP11 = 4'd11;
  localparam logic [IDX_W-1:0] W_TCP12 = 4'd12;
  localparam logic [IDX_W-1:0] W_TCP13 = 4'd13;
  localparam logic [IDX_W-1:0] W_SAT   = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_SKIP,
    ST_EMIT
  } parser_state_t;

  typedef struct packed {
    logic [47:0] mac_dst;
    logic [47:0] mac_src;
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  tcp_flags;
    logic [15:0] window;
    logic [15:0] payload_len;
  } tcp_hdr_t;

endpackage

// File: rtl/parser_checks.sv
// Per-word header validation: flags a frame the TOE must not accept as the
// offending word arrives.
module parser_checks
  import toe_pkg::*;
#(
  parameter bit          FILTER_MAC = 1'b1,
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] data,
  input  logic [31:0]       mac_dst_hi,
  input  logic [15:0]       ip_len,
  output logic              err_c
);

  logic [3:0]  doff;
  logic [47:0] dst;
  logic [15:0] min_len;

  always_comb begin
    err_c   = 1'b0;
    doff    = data[15:12];
    dst     = {mac_dst_hi, data[31:16]};
    min_len = 16'd20 + {10'd0, doff, 2'b00};
    case (idx)
      W_ETH1:  err_c = FILTER_MAC && (dst != LOCAL_MAC) && (dst != MAC_BROADCAST);
      W_ETH3:  err_c = (data[31:16] != ETH_TYPE_IPV4) || (data[15:12] != IP_VERSION) ||
                       (data[11:8] != IP_IHL);
      W_IP5:   err_c = (data[7:0] != IP_PROTO_TCP);
      // Checked before payload_len is formed so the subtraction cannot underflow.
      W_TCP11: err_c = (doff < TCP_DOFF_MIN) || (ip_len < min_len);
      default: err_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/packet_parser.sv
// RX header parser: extracts Ethernet/IPv4/TCP fields from a 32-bit word stream
// into one header record; malformed or filtered frames are dropped and counted.
module packet_parser
  import toe_pkg::*;
#(
  parameter bit          FILTER_MAC = 1'b1,
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             in_ready,
  output logic             hdr_valid,
  input  logic             hdr_ready,
  output logic [47:0]      mac_dst,
  output logic [47:0]      mac_src,
  output logic [31:0]      ip_src,
  output logic [31:0]      ip_dst,
  output logic [15:0]      src_port,
  output logic [15:0]      dst_port,
  output logic [31:0]      seq_num,
  output logic [31:0]      ack_num,
  output logic [7:0]       tcp_flags,
  output logic [15:0]      window,
  output logic [15:0]      payload_len,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] drop_count
);

  parser_state_t    state, state_nxt;
  logic [IDX_W-1:0] wcnt, wcnt_nxt, cur_idx;
  tcp_hdr_t         hdr_q;
  logic [15:0]      ip_len_q;
  logic             acc, cap_en, rx_inc, chk_err_c;
  logic [1:0]       drop_inc;
  logic             in_ready_q, hdr_valid_q;

  parser_checks #(
    .FILTER_MAC (FILTER_MAC),
    .LOCAL_MAC  (LOCAL_MAC)
  ) u_checks (
    .idx        (cur_idx),
    .data       (in_data),
    .mac_dst_hi (hdr_q.mac_dst[47:16]),
    .ip_len     (ip_len_q),
    .err_c      (chk_err_c)
  );

  // Next-state, capture enable and counter increments.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    drop_inc  = 2'd0;
    rx_inc    = 1'b0;
    cap_en    = 1'b0;
    acc       = in_valid && in_ready_q;
    cur_idx   = in_sop ? W_ETH0 : wcnt;
    case (state)
      ST_IDLE: begin
        if (acc && in_sop) begin
          cap_en = 1'b1;
          if (in_eop) drop_inc = 2'd1;
          else        state_nxt = ST_HDR;
        end
      end
      ST_HDR, ST_SKIP: begin
        if (acc) begin
          if (in_sop) begin
            // Abort the frame in flight; a runt restart is a second drop.
            cap_en = 1'b1;
            if (in_eop) begin
              drop_inc  = 2'd2;
              state_nxt = ST_IDLE;
            end else begin
              drop_inc  = 2'd1;
              state_nxt = ST_HDR;
            end
          end else if (state == ST_SKIP) begin
            if (in_eop) begin
              drop_inc  = 2'd1;
              state_nxt = ST_IDLE;
            end
          end else begin
            cap_en = 1'b1;
            if (in_eop) begin
              if (wcnt >= W_TCP13 && !chk_err_c) begin
                state_nxt = ST_EMIT;
              end else begin
                drop_inc  = 2'd1;
                state_nxt = ST_IDLE;
              end
            end else if (chk_err_c) begin
              state_nxt = ST_SKIP;
            end
          end
        end
      end
      ST_EMIT: begin
        if (hdr_ready) begin
          rx_inc    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (cap_en) wcnt_nxt = (cur_idx == W_SAT) ? W_SAT : cur_idx + 4'd1;
    if (state_nxt != ST_HDR) wcnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      in_ready_q  <= 1'b1;
      hdr_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      wcnt        <= wcnt_nxt;
      in_ready_q  <= (state_nxt != ST_EMIT);
      hdr_valid_q <= (state_nxt == ST_EMIT);
    end
  end

  // Header field capture by word index; frozen while the record is offered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_q    <= '0;
      ip_len_q <= '0;
    end else if (cap_en) begin
      case (cur_idx)
        W_ETH0: hdr_q.mac_dst[47:16] <= in_data;
        W_ETH1: begin
          hdr_q.mac_dst[15:0]  <= in_data[31:16];
          hdr_q.mac_src[47:32] <= in_data[15:0];
        end
        W_ETH2: hdr_q.mac_src[31:0] <= in_data;
        W_IP4:  ip_len_q <= in_data[31:16];
        W_IP6:  hdr_q.ip_src[31:16] <= in_data[15:0];
        W_IP7: begin
          hdr_q.ip_src[15:0]  <= in_data[31:16];
          hdr_q.ip_dst[31:16] <= in_data[15:0];
        end
        W_IP8: begin
          hdr_q.ip_dst[15:0] <= in_data[31:16];
          hdr_q.src_port     <= in_data[15:0];
        end
        W_TCP9: begin
          hdr_q.dst_port       <= in_data[31:16];
          hdr_q.seq_num[31:16] <= in_data[15:0];
        end
        W_TCP10: begin
          hdr_q.seq_num[15:0]  <= in_data[31:16];
          hdr_q.ack_num[31:16] <= in_data[15:0];
        end
        W_TCP11: begin
          hdr_q.ack_num[15:0] <= in_data[31:16];
          hdr_q.tcp_flags     <= in_data[7:0];
          hdr_q.payload_len   <= ip_len_q - 16'd20 - {10'd0, in_data[15:12], 2'b00};
        end
        W_TCP12: hdr_q.window <= in_data[31:16];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      rx_count   <= rx_count + CNT_W'(rx_inc);
      drop_count <= drop_count + CNT_W'(drop_inc);
    end
  end

  assign in_ready    = in_ready_q;
  assign hdr_valid   = hdr_valid_q;
  assign mac_dst     = hdr_q.mac_dst;
  assign mac_src     = hdr_q.mac_src;
  assign ip_src      = hdr_q.ip_src;
  assign ip_dst      = hdr_q.ip_dst;
  assign src_port    = hdr_q.src_port;
  assign dst_port    = hdr_q.dst_port;
  assign seq_num     = hdr_q.seq_num;
  assign ack_num     = hdr_q.ack_num;
  assign tcp_flags   = hdr_q.tcp_flags;
  assign window      = hdr_q.window;
  assign payload_len = hdr_q.payload_len;

endmodule

// File: tb/tb_packet_parser.sv
// Bench for packet_parser: vector table, hand-written corner sequences and
// random frames judged by a frame-level acceptance model.
module tb_packet_parser;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

  logic        clk, reset;
  logic [31:0] in_data;
  logic        in_valid, in_sop, in_eop, in_ready;
  logic        hdr_valid, hdr_ready;
  logic [47:0] mac_dst, mac_src;
  logic [31:0] ip_src, ip_dst, seq_num, ack_num;
  logic [15:0] src_port, dst_port, window, payload_len;
  logic [7:0]  tcp_flags;
  logic [15:0] rx_count, drop_count;

  packet_parser #(.FILTER_MAC(1'b1), .LOCAL_MAC(LOCAL_MAC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .mac_dst(mac_dst), .mac_src(mac_src), .ip_src(ip_src), .ip_dst(ip_dst),
    .src_port(src_port), .dst_port(dst_port), .seq_num(seq_num), .ack_num(ack_num),
    .tcp_flags(tcp_flags), .window(window), .payload_len(payload_len),
    .rx_count(rx_count), .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] dst, src;
    logic [15:0] etype;
    logic [3:0]  ver, ihl;
    logic [7:0]  proto;
    logic [15:0] ip_len;
    logic [31:0] ip_src, ip_dst;
    logic [15:0] sport, dport;
    logic [31:0] seq, ack;
    logic [3:0]  doff;
    logic [7:0]  flags;
    logic [15:0] window;
  } frame_t;

  typedef struct {
    string       name;
    frame_t      f;
    int          n;
    int          hold;
    bit          exp_emit;
    logic [15:0] exp_plen;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int exp_rx = 0;
  int exp_drop = 0;
  logic [31:0] fw[$];
  vec_t vq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t good_frame();
    frame_t f;
    f.dst = LOCAL_MAC;         f.src = {16'h0200, $urandom};
    f.etype = 16'h0800;        f.ver = 4'd4;        f.ihl = 4'd5;
    f.proto = 8'd6;            f.ip_len = 16'd40;
    f.ip_src = $urandom;       f.ip_dst = $urandom;
    f.sport = 16'($urandom);   f.dport = 16'($urandom);
    f.seq = $urandom;          f.ack = $urandom;
    f.doff = 4'd5;             f.flags = 8'h10;     f.window = 16'($urandom);
    return f;
  endfunction

  // Frame-level acceptance rules; payload length in plain integer arithmetic.
  function automatic bit model(input frame_t f, input int n, output logic [15:0] plen);
    int  hlen;
    bit  mac_ok;
    hlen   = 20 + 4 * int'(f.doff);
    mac_ok = (f.dst == LOCAL_MAC) || (f.dst == BCAST);
    plen   = 16'(int'(f.ip_len) - hlen);
    return (n >= 14) && (f.etype == 16'h0800) && (f.ver == 4'd4) && (f.ihl == 4'd5) &&
           (f.proto == 8'd6) && (f.doff >= 4'd5) && (int'(f.ip_len) >= hlen) && mac_ok;
  endfunction

  task automatic build(input frame_t f, input int n);
    logic [31:0] w[14];
    w[0]  = f.dst[47:16];
    w[1]  = {f.dst[15:0], f.src[47:32]};
    w[2]  = f.src[31:0];
    w[3]  = {f.etype, f.ver, f.ihl, 8'h00};
    w[4]  = {f.ip_len, 16'h1234};
    w[5]  = {16'h4000, 8'd64, f.proto};
    w[6]  = {16'hbeef, f.ip_src[31:16]};
    w[7]  = {f.ip_src[15:0], f.ip_dst[31:16]};
    w[8]  = {f.ip_dst[15:0], f.sport};
    w[9]  = {f.dport, f.seq[31:16]};
    w[10] = {f.seq[15:0], f.ack[31:16]};
    w[11] = {f.ack[15:0], f.doff, 4'h0, f.flags};
    w[12] = {f.window, 16'hcafe};
    w[13] = $urandom;
    fw.delete();
    for (int i = 0; i < n; i++) fw.push_back(i < 14 ? w[i] : $urandom);
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic drive_beat(input logic [31:0] d, input logic sop, input logic eop);
    bit ok;
    int g;
    in_data = d; in_sop = sop; in_eop = eop; in_valid = 1'b1;
    g = 0;
    do begin
      ok = in_ready;
      @(posedge clk);
      g++;
    end while (!ok && g < 20);
    if (!ok) chk("in_ready_wait", 64'(ok), 64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic chk_rec(input string tag, input frame_t f, input logic [15:0] plen);
    chk({tag, ".mac_dst"}, mac_dst, f.dst);
    chk({tag, ".mac_src"}, mac_src, f.src);
    chk({tag, ".ip_src"}, ip_src, f.ip_src);
    chk({tag, ".ip_dst"}, ip_dst, f.ip_dst);
    chk({tag, ".ports"}, {src_port, dst_port}, {f.sport, f.dport});
    chk({tag, ".seq"}, seq_num, f.seq);
    chk({tag, ".ack"}, ack_num, f.ack);
    chk({tag, ".flags"}, tcp_flags, f.flags);
    chk({tag, ".window"}, window, f.window);
    chk({tag, ".plen"}, payload_len, plen);
  endtask

  task automatic run_frame(input string tag, input frame_t f, input int n, input int hold,
                           input bit emit, input logic [15:0] plen);
    build(f, n);
    hdr_ready = (hold == 0);
    for (int i = 0; i < n; i++) drive_beat(fw[i], i == 0, i == n - 1);
    if (emit) begin
      chk({tag, ".hv"}, hdr_valid, 1);
      chk_rec(tag, f, plen);
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        chk({tag, ".hv_hold"}, hdr_valid, 1);
        chk({tag, ".rdy_hold"}, in_ready, 0);
        chk_rec(tag, f, plen);
      end
      hdr_ready = 1'b1;
      @(negedge clk);
      exp_rx++;
      chk({tag, ".hv_done"}, hdr_valid, 0);
      chk({tag, ".rdy_done"}, in_ready, 1);
    end else begin
      chk({tag, ".no_hv"}, hdr_valid, 0);
      @(negedge clk);
      chk({tag, ".no_hv2"}, hdr_valid, 0);
      exp_drop++;
    end
    hdr_ready = 1'b0;
    chk({tag, ".rx_count"}, rx_count, 16'(exp_rx));
    chk({tag, ".drop_count"}, drop_count, 16'(exp_drop));
  endtask

  function automatic vec_t mk(input string name, input int n, input int hold,
                              input bit emit, input logic [15:0] plen);
    vec_t v;
    v.name = name; v.f = good_frame(); v.n = n; v.hold = hold;
    v.exp_emit = emit; v.exp_plen = plen;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    frame_t      f;
    bit          emit;
    logic [15:0] plen;
    int          hl;

    v = mk("syn", 14, 0, 1, 16'd0);      v.f.flags = 8'h02; v.f.seq = 32'h1000_0000; vq.push_back(v);
    v = mk("pay100", 39, 5, 1, 16'd100); v.f.ip_len = 16'd140;                        vq.push_back(v);
    v = mk("arp", 15, 0, 0, 16'd0);      v.f.etype = 16'h0806;                        vq.push_back(v);
    v = mk("after_arp", 14, 1, 1, 16'd0);                                            vq.push_back(v);
    v = mk("runt_w9", 10, 0, 0, 16'd0);                                              vq.push_back(v);
    v = mk("mac_other", 14, 0, 0, 16'd0); v.f.dst = 48'h02_00_00_00_00_02;           vq.push_back(v);
    v = mk("mac_bcast", 14, 0, 1, 16'd0); v.f.dst = BCAST;                           vq.push_back(v);
    v = mk("mac_local", 14, 2, 1, 16'd0);                                            vq.push_back(v);
    v = mk("doff6", 14, 0, 1, 16'd0);    v.f.doff = 4'd6; v.f.ip_len = 16'd44;       vq.push_back(v);
    v = mk("doff4", 14, 0, 0, 16'd0);    v.f.doff = 4'd4;                            vq.push_back(v);
    v = mk("udp", 14, 0, 0, 16'd0);      v.f.proto = 8'd17;                          vq.push_back(v);
    v = mk("ihl6", 14, 0, 0, 16'd0);     v.f.ihl = 4'd6;                             vq.push_back(v);
    v = mk("ver6", 14, 0, 0, 16'd0);     v.f.ver = 4'd6;                             vq.push_back(v);
    v = mk("iplen39", 14, 0, 0, 16'd0);  v.f.ip_len = 16'd39;                        vq.push_back(v);
    v = mk("iplen_max", 14, 0, 1, 16'hFFAF); v.f.ip_len = 16'hFFFF; v.f.doff = 4'd15; vq.push_back(v);
    v = mk("eop_w12", 13, 0, 0, 16'd0);                                              vq.push_back(v);
    v = mk("runt1", 1, 0, 0, 16'd0);                                                 vq.push_back(v);
    v = mk("long", 20, 3, 1, 16'd0);                                                 vq.push_back(v);

    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_data = '0; hdr_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.in_ready", in_ready, 1);
    chk("rst.hdr_valid", hdr_valid, 0);
    chk("rst.counters", {rx_count, drop_count}, 32'd0);
    chk("rst.fields", {mac_dst, payload_len, seq_num}, 96'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vq[i]) run_frame(vq[i].name, vq[i].f, vq[i].n, vq[i].hold, vq[i].exp_emit, vq[i].exp_plen);

    // sop at w6 aborts the frame in flight; the restarted frame emits.
    f = good_frame();
    build(f, 14);
    for (int i = 0; i < 6; i++) drive_beat(fw[i], i == 0, 1'b0);
    exp_drop++;
    run_frame("abort_w6", good_frame(), 14, 0, 1, 16'd0);

    // Words without sop while idle are discarded without any count.
    for (int i = 0; i < 3; i++) drive_beat($urandom, 1'b0, i == 2);
    chk("junk.counters", {rx_count, drop_count}, {16'(exp_rx), 16'(exp_drop)});
    chk("junk.hdr_valid", hdr_valid, 0);
    run_frame("after_junk", good_frame(), 14, 0, 1, 16'd0);

    // Reset while w5 is on the bus discards the frame and clears everything.
    f = good_frame();
    build(f, 14);
    for (int i = 0; i < 5; i++) drive_beat(fw[i], i == 0, 1'b0);
    in_data = fw[5]; in_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("rst5.counters", {rx_count, drop_count}, 32'd0);
    chk("rst5.fields", {mac_dst, mac_src, payload_len}, 112'd0);
    chk("rst5.in_ready", in_ready, 1);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_rx = 0; exp_drop = 0;
    repeat (3) @(negedge clk);
    chk("rst5.no_hv", hdr_valid, 0);
    chk("rst5.counters2", {rx_count, drop_count}, 32'd0);
    run_frame("after_rst", good_frame(), 14, 0, 1, 16'd0);

    // Random frames judged by the acceptance model.
    for (int k = 0; k < 60; k++) begin
      int n;
      f = good_frame();
      case ($urandom_range(0, 9))
        0: f.etype = ($urandom_range(0, 1) == 0) ? 16'h86DD : 16'($urandom);
        1: case ($urandom_range(0, 2))
             0: f.dst = BCAST;
             1: f.dst = {16'h0200, $urandom};
             default: f.dst = LOCAL_MAC;
           endcase
        2: f.proto = 8'($urandom_range(0, 20));
        3: f.doff = 4'($urandom_range(0, 15));
        4: f.ver = 4'($urandom_range(3, 6));
        5: f.ihl = 4'($urandom_range(4, 7));
        default: f.doff = 4'($urandom_range(5, 15));
      endcase
      hl = 20 + 4 * int'(f.doff) + int'($urandom_range(0, 200));
      if ($urandom_range(0, 3) == 0) hl = hl - int'($urandom_range(1, 8)) - 200;
      if (hl < 0) hl = 0;
      f.ip_len = 16'(hl);
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 13)) : int'($urandom_range(14, 24));
      emit = model(f, n, plen);
      run_frame($sformatf("rnd%0d", k), f, n, int'($urandom_range(0, 3)), emit, plen);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/packet_parser.md
Name: packet_parser

Overview:
- Receive-side counterpart of the TX packet builder.
- Consumes an inbound Ethernet/IPv4/TCP frame as a 32-bit big-endian word stream and extracts the header fields the TOE needs to look up and update a connection record.
- Presents them as one header record on a valid/ready output. Frames that are non-IPv4, non-TCP, carry IP options, are runts or are filtered are dropped and counted.

Parameters:
- FILTER_MAC, 1, when 1 drop frames whose dst MAC is neither LOCAL_MAC nor FF:FF:FF:FF:FF:FF
- LOCAL_MAC, 48'h02_00_00_00_00_01, station MAC used by the filter
- CNT_W, 16, width of the statistics counters

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_data  in  32  frame word; first byte on wire in [31:24]
- in_valid  in  1  in_data valid
- in_sop  in  1  first word of frame (qualified by in_valid)
- in_eop  in  1  last word of frame (qualified by in_valid)
- in_ready  out  1  parser accepts a word when in_valid && in_ready
- hdr_valid  out  1  header record valid
- hdr_ready  in  1  consumer accepts record
- mac_dst, mac_src  out  48 each  Ethernet addresses
- ip_src, ip_dst  out  32 each  IPv4 addresses
- src_port, dst_port  out  16 each  TCP ports
- seq_num, ack_num  out  32 each  TCP sequence / ack
- tcp_flags  out  8  CWR..FIN
- window  out  16  TCP window
- payload_len  out  16  ip_len − 20 − 4·data_offset
- rx_count  out  CNT_W  frames emitted
- drop_count  out  CNT_W  frames dropped

Behaviour:
- Reset: state IDLE, word counter 0, in_ready=1, hdr_valid=0, all field outputs 0, both counters 0. Reset mid-frame discards the frame with no count.
- Word map (w = index within frame):
  - w0 mac_dst[47:16]; w1 mac_dst[15:0],mac_src[47:32]; w2 mac_src[31:0]
  - w3 eth_type, ver/ihl, tos; w4 ip_len, id; w5 frag, ttl, proto
  - w6 ip_csum, ip_src[31:16]; w7 ip_src[15:0], ip_dst[31:16]; w8 ip_dst[15:0], src_port
  - w9 dst_port, seq[31:16]; w10 seq[15:0], ack[31:16]; w11 ack[15:0], doff[15:12], flags[7:0]
  - w12 window, tcp_csum; w13 urgent pointer + payload (ignored)
  - Words beyond w13 are ignored.
- States:
  - IDLE: wait for an accepted word with in_sop. Capture it as w0 and go to HDR; if it also has eop, drop as a runt. Words accepted without sop are discarded silently, with no count.
  - HDR: capture w1..w13 into the record registers; the counter saturates at 14. Check errors as fields arrive. eop → if counter reached w13 and no error then EMIT, else drop → IDLE.
  - SKIP: entered at the first error before eop; consume words until eop, then drop → IDLE.
  - EMIT: in_ready=0 and hdr_valid=1; outputs are held stable until hdr_valid && hdr_ready, then rx_count++ → IDLE. hdr_valid rises the cycle after the eop beat is accepted.
- Drop/error conditions:
  - eth_type≠16'h0800, version≠4, ihl≠5, proto≠8'd6
  - doff<5
  - ip_len < 20+4·doff
  - MAC mismatch when FILTER_MAC=1
  - eop before w13
- Each drop increments drop_count exactly once, in the cycle the eop beat is accepted.
- payload_len is computed in 16-bit unsigned arithmetic after the range check, so it never underflows.
- An accepted in_sop while in HDR or SKIP aborts the current frame: drop_count++ and the word is restarted as w0. An eop on the same beat applies the runt rule.
- Counters wrap modulo 2^CNT_W.
- in_ready is 1 in IDLE, HDR and SKIP. Throughput is 1 word/cycle plus 1 emit cycle when hdr_ready is held high.

Decomposition:
- Package toe_pkg holds: ETH_TYPE_IPV4, IP_PROTO_TCP, MAC_BROADCAST, the word index constants W_ETH0..W_TCP13, the parser state enum, and a packed struct tcp_hdr_t (fields above) shared with the packet builder.
- One sub-module, parser_checks: combinational per-word field validation returning an error bit, driven by word index and data.

Test Plan:
- Valid SYN: eth 0800, ip_len 40, proto 6, doff 5, flags 8'h02, seq 32'h1000_0000; hdr_ready=1 → hdr_valid one cycle after eop, payload_len=0, rx_count=1.
- 100-byte payload (ip_len 140, doff 5), hdr_ready low 5 cycles → record held stable, in_ready=0 throughout, payload_len=100.
- eth_type 16'h0806 (ARP), 15 words → no hdr_valid, drop_count=1, next valid frame parsed normally.
- Runt: eop on w9 → drop_count=1; and sop at w6 of a good frame → drop_count=1, the new frame emits.
- FILTER_MAC=1: dst 02:00:00:00:00:02 dropped; dst FF:FF:FF:FF:FF:FF accepted; dst LOCAL_MAC accepted.
- doff=6, ip_len 44 → payload_len=0; doff=4 → dropped; reset asserted at w5 → outputs and counters 0, no emit.
